// File: rtl/ctrl_data_burst.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_data_burst
//  Description : DQS/DQ burst sequencer downstream of the rd/wr timing
//                controller. Runs preamble, toggling burst and postamble,
//                and queues requests so same-direction bursts chain seamlessly.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_data_burst #(
    parameter int DQ_W   = 8,
    parameter int QDEPTH = 2
) (
    input  logic            CK_t,
    input  logic            reset,
    input  logic            rd_rdy,
    input  logic            wr_rdy,
    input  logic            bc4,
    input  logic [1:0]      RD_PRE,
    input  logic [1:0]      WR_PRE,
    input  logic [DQ_W-1:0] wr_data,
    output logic            wr_data_req,
    input  logic [DQ_W-1:0] dq_in,
    output logic [DQ_W-1:0] dq_out,
    output logic            dq_oe,
    output logic            dqs_t_out,
    output logic            dqs_oe,
    output logic [DQ_W-1:0] rd_data,
    output logic            rd_data_valid,
    output logic            burst_done,
    output logic            busy,
    output logic            err
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_BURST = 2'd2,
        S_POST  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_dir, w_dir_nxt;      // 1 = write, 0 = read
    logic                r_bc4, w_bc4_nxt;
    logic [1:0]          r_pre_cnt, w_pre_nxt;
    logic [2:0]          r_beat, w_beat_nxt;
    logic                w_take;

    logic [1:0]          r_q_mem [QDEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [c_CNT_W-1:0]  r_q_cnt, w_q_cnt_nxt;

    logic                r_dqs_oe, r_dqs_t, r_dq_oe, r_burst_done, r_busy, r_err;
    logic                r_rd_valid;
    logic [DQ_W-1:0]     r_dq_out, r_rd_data;

    logic                w_req_v, w_req_dir, w_q_empty, w_q_full, w_avail;
    logic [1:0]          w_head, w_head_pre;
    logic                w_last, w_seamless;
    logic                w_bypass, w_store, w_deq, w_overflow, w_dq_oe_nxt;

    function automatic logic [1:0] f_pre_len(input logic [1:0] p);
        f_pre_len = (p == 2'd2) ? 2'd2 : 2'd1;
    endfunction

    // A read wins a rd/wr collision; an incoming pulse is visible as the
    // queue head when the queue is empty, so it can be taken the same cycle.
    assign w_req_v    = rd_rdy | wr_rdy;
    assign w_req_dir  = ~rd_rdy;
    assign w_q_empty  = (r_q_cnt == '0);
    assign w_q_full   = (r_q_cnt == c_CNT_W'(QDEPTH));
    assign w_avail    = !w_q_empty || w_req_v;
    assign w_head     = w_q_empty ? {w_req_dir, bc4} : r_q_mem[r_rd_ptr];
    assign w_head_pre = f_pre_len(w_head[1] ? WR_PRE : RD_PRE);
    assign w_last     = (r_beat == (r_bc4 ? 3'd3 : 3'd7));
    assign w_seamless = (r_state == S_BURST) && w_last && w_avail && (w_head[1] == r_dir);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_bc4_nxt   = r_bc4;
        w_pre_nxt   = r_pre_cnt;
        w_beat_nxt  = r_beat;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE, S_POST: begin
                if (w_avail) begin
                    w_take      = 1'b1;
                    w_dir_nxt   = w_head[1];
                    w_bc4_nxt   = w_head[0];
                    w_pre_nxt   = w_head_pre;
                    w_state_nxt = S_PRE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PRE: begin
                if (r_pre_cnt <= 2'd1) begin
                    w_state_nxt = S_BURST;
                    w_beat_nxt  = 3'd0;
                end
                if (r_pre_cnt != 2'd0) begin
                    w_pre_nxt = r_pre_cnt - 2'd1;
                end
            end
            S_BURST: begin
                if (!w_last) begin
                    w_beat_nxt = r_beat + 3'd1;
                end else if (w_seamless) begin
                    w_take     = 1'b1;
                    w_bc4_nxt  = w_head[0];
                    w_beat_nxt = 3'd0;
                end else begin
                    w_state_nxt = S_POST;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Combinational so a write arriving on the last beat still gets its
    // first-beat request in time for a seamless continuation.
    assign wr_data_req = r_dir &&
                         (((r_state == S_PRE) && (r_pre_cnt == 2'd1)) ||
                          ((r_state == S_BURST) && (!w_last || w_seamless)));

    // Push and pop together keep occupancy; an empty-queue take is a bypass.
    assign w_bypass    = w_take && w_q_empty;
    assign w_store     = w_req_v && !w_bypass && (!w_q_full || w_take);
    assign w_deq       = w_take && !w_q_empty;
    assign w_overflow  = w_req_v && w_q_full && !w_take;
    assign w_q_cnt_nxt = r_q_cnt + c_CNT_W'(w_store) - c_CNT_W'(w_deq);
    assign w_dq_oe_nxt = w_dir_nxt && ((w_state_nxt == S_PRE) || (w_state_nxt == S_BURST));

    always_ff @(posedge CK_t) begin
        if (w_store) begin
            r_q_mem[r_wr_ptr] <= {w_req_dir, bc4};
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dir        <= 1'b0;
            r_bc4        <= 1'b0;
            r_pre_cnt    <= 2'd0;
            r_beat       <= 3'd0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_q_cnt      <= '0;
            r_dqs_oe     <= 1'b0;
            r_dqs_t      <= 1'b0;
            r_dq_oe      <= 1'b0;
            r_burst_done <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_dq_out     <= '0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_dir        <= w_dir_nxt;
            r_bc4        <= w_bc4_nxt;
            r_pre_cnt    <= w_pre_nxt;
            r_beat       <= w_beat_nxt;
            r_q_cnt      <= w_q_cnt_nxt;
            if (w_store) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_deq)   r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_dqs_oe     <= (w_state_nxt != S_IDLE);
            r_dqs_t      <= (w_state_nxt == S_BURST) && !w_beat_nxt[0];
            r_dq_oe      <= w_dq_oe_nxt;
            r_burst_done <= (w_state_nxt == S_BURST) &&
                            (w_beat_nxt == (w_bc4_nxt ? 3'd3 : 3'd7));
            r_busy       <= (w_state_nxt != S_IDLE) || (w_q_cnt_nxt != '0);
            r_err        <= r_err | w_overflow | (rd_rdy & wr_rdy);
            r_rd_valid   <= (r_state == S_BURST) && !r_dir;
            if ((r_state == S_BURST) && !r_dir) begin
                r_rd_data <= dq_in;
            end
            if (wr_data_req) begin
                r_dq_out <= wr_data;
            end else if (!w_dq_oe_nxt) begin
                r_dq_out <= '0;
            end
        end
    end

    assign dqs_oe        = r_dqs_oe;
    assign dqs_t_out     = r_dqs_t;
    assign dq_oe         = r_dq_oe;
    assign dq_out        = r_dq_out;
    assign burst_done    = r_burst_done;
    assign busy          = r_busy;
    assign err           = r_err;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: doc/ctrl_data_burst.md
Name: ctrl_data_burst

Overview:
- Data-path stage directly downstream of the read/write timing controller.
- Consumes its one-cycle rd_rdy/wr_rdy pulses, which mark the first preamble cycle of a burst.
- For each pulse it generates the DQS preamble, toggling DQS, DQ drive (writes) or DQ capture (reads), and the postamble on a single-data-rate bus model (one beat per CK_t).
- Queues bursts that arrive before the current one finishes, so back-to-back CAS traffic is sustained.

Parameters:
DQ_W, 8, DQ bus width (x8 device)
QDEPTH, 2, pending-burst queue depth (power of 2, ≥2)

Ports:
CK_t  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rd_rdy  in  1  one-cycle pulse: start read burst
wr_rdy  in  1  one-cycle pulse: start write burst
bc4  in  1  burst chop, sampled with rd_rdy/wr_rdy: 1 = 4 beats, 0 = 8 beats
RD_PRE  in  2  read preamble cycles, legal values 1 or 2
WR_PRE  in  2  write preamble cycles, legal values 1 or 2
wr_data  in  DQ_W  write beat data, valid in the cycle wr_data_req is high
wr_data_req  out  1  request the next write beat
dq_in  in  DQ_W  DQ from memory model
dq_out  out  DQ_W  DQ drive value
dq_oe  out  1  DQ output enable
dqs_t_out  out  1  DQS_t drive value
dqs_oe  out  1  DQS output enable
rd_data  out  DQ_W  captured read beat
rd_data_valid  out  1  rd_data valid
burst_done  out  1  one-cycle pulse on the last beat of every burst
busy  out  1  FSM not in IDLE, or queue non-empty
err  out  1  sticky: queue overflow or simultaneous rd_rdy & wr_rdy

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; queue empty; beat and preamble counters 0.
- Reset asserted mid-burst aborts immediately: oe signals drop asynchronously and queued bursts are discarded.

Queue:
- Each entry holds {dir, bc4}.
- A pulse is pushed in the same cycle it arrives, unless the FSM is IDLE with an empty queue; in that case it is consumed directly.
- Push while full: request dropped, err set.
- rd_rdy & wr_rdy together: read accepted, write dropped, err set.
- err clears only on reset.

FSM (IDLE, PRE, BURST, POST); all outputs registered:
- IDLE: on a request (direct or queue head), latch dir/bc4, load pre_cnt = RD_PRE or WR_PRE (sampled then; 0 or 3 treated as 1), go to PRE.
- PRE: dqs_oe=1, dqs_t_out=0; dq_oe=1 for writes. Decrement pre_cnt; at 1, go to BURST with beat=0.
- BURST, beat n: dqs_t_out = ~n[0] (high on beat 0); dqs_oe=1.
  - Write: dq_oe=1, dq_out = data captured on the wr_data_req cycle for beat n.
  - Read: dq_oe=0; dq_in sampled; rd_data/rd_data_valid appear next cycle (1-cycle latency).
  - Last beat (3 if bc4, else 7): burst_done=1.
  - If the queue is non-empty and the head has the same dir: pop, reload, stay in BURST with beat=0. This is a seamless burst: no preamble or postamble, DQS keeps toggling.
  - Otherwise go to POST.
- POST (1 cycle): dqs_oe=1, dqs_t_out=0, dq_oe=0. Then:
  - queue non-empty: pop and go to PRE;
  - queue empty: go to IDLE.
  - A direction change therefore always costs POST + PRE.

wr_data_req:
- High exactly one cycle before each write beat.
- First beat: the last PRE cycle. Subsequent beats: BURST cycles except the last beat of a burst with no seamless follow-on.
- Total req count per write burst = beat count.

Boundaries:
- A pulse on the same cycle as burst_done is pushed first, so it is eligible for seamless continuation.
- A queue push and pop in the same cycle leaves occupancy unchanged, even when full.

Test Plan:
1. reset, then WR_PRE=1, wr_rdy, bc4=0, wr_data=0x10..0x17 -> 1 PRE, dq_out 0x10..0x17 over 8 cycles, dqs_t_out 1,0,1,0…, burst_done on beat 7, POST, IDLE; 10 cycles total.
2. RD_PRE=2, rd_rdy, bc4=1, dq_in=0xA0..0xA3 -> 2 PRE cycles with dq_oe=0, rd_data 0xA0..0xA3 one cycle after each beat, 4 valids.
3. Two wr_rdy 8 cycles apart, BL8 -> 16 contiguous beats, single preamble, single POST, 2 burst_done pulses.
4. Read then write queued during the read -> read, POST, WR_PRE preamble, write; dq_oe never high during read beats.
5. Three requests queued during an active burst (QDEPTH=2) -> third dropped, err=1; the two queued bursts complete.
6. Reset asserted on beat 3 of a write -> dq_oe/dqs_oe 0 immediately, queue empty, busy=0; next wr_rdy after release runs normally.
